// File: rtl/sd_dat_read_ctrl.sv
// sd_dat_read_ctrl: Avalon-MM slave that reads one 512-byte 4-bit SD data block into a
// 128x32 buffer, checking a CRC16 on each DAT line and the end bits.
module sd_dat_read_ctrl #(
   parameter int CLK_DIV = 4,
   parameter int TIMEOUT = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        read_n,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq,
   output logic        sd_clk,
   input  logic [3:0]  sd_dat_in
);
   localparam logic [2:0] IDLE = 3'd0, WAIT_START = 3'd1, DATA = 3'd2, CRC = 3'd3, END = 3'd4;
   logic [2:0] state;
   logic [7:0] div_cnt;
   logic [15:0] to_cnt;
   logic [9:0] bit_cnt, count;
   logic [6:0] rd_ptr;
   logic [3:0] nib_hi;
   logic [23:0] word_lo;
   logic [3:0][15:0] crc, crc_nxt;
   logic done, crc_err, timeout, ie;
   logic [31:0] buffer [128];
   logic busy, half, tick, wr, rd, buf_we, crc_bad, unused_wd;
   logic [7:0] byte_in;
   assign busy = state != IDLE;
   assign half = div_cnt == 8'(CLK_DIV - 1);
   assign tick = busy && half && !sd_clk;
   assign wr = chipselect && !write_n;
   assign rd = chipselect && !read_n;
   assign byte_in = {nib_hi, sd_dat_in};
   assign buf_we = tick && state == DATA && bit_cnt[2:0] == 3'd7;
   assign crc_bad = |(sd_dat_in ^ {crc[3][15], crc[2][15], crc[1][15], crc[0][15]});
   assign irq = done && ie;
   assign unused_wd = ^writedata[31:4];
   always_comb
      for (int i = 0; i < 4; i++)
         crc_nxt[i] = {crc[i][14:0], 1'b0} ^ ((sd_dat_in[i] ^ crc[i][15]) ? 16'h1021 : 16'h0000);
   // bytes arrive low lane first, so shift down and append the 4th byte on top
   always_ff @(posedge clk)
      if (buf_we) buffer[bit_cnt[9:3]] <= {byte_in, word_lo};
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         sd_clk <= 1'b0;
         div_cnt <= '0;
         to_cnt <= '0;
         bit_cnt <= '0;
         count <= '0;
         rd_ptr <= '0;
         nib_hi <= '0;
         word_lo <= '0;
         crc <= '0;
         done <= 1'b0;
         crc_err <= 1'b0;
         timeout <= 1'b0;
         ie <= 1'b0;
         readdata <= '0;
      end else begin
         if (busy) begin
            div_cnt <= half ? 8'd0 : div_cnt + 8'd1;
            sd_clk <= half ? !sd_clk : sd_clk;
         end
         if (wr && address == 2'd1) begin
            done <= done && !writedata[1];
            crc_err <= crc_err && !writedata[2];
            timeout <= timeout && !writedata[3];
         end
         if (tick)
            case (state)
               WAIT_START:
                  if (!sd_dat_in[0]) state <= DATA;
                  else if (to_cnt == 16'(TIMEOUT - 1)) begin
                     timeout <= 1'b1;
                     done <= 1'b1;
                     state <= IDLE;
                     sd_clk <= 1'b0;
                     div_cnt <= '0;
                  end else to_cnt <= to_cnt + 16'd1;
               DATA: begin
                  crc <= crc_nxt;
                  bit_cnt <= bit_cnt + 10'd1;
                  nib_hi <= bit_cnt[0] ? nib_hi : sd_dat_in;
                  if (bit_cnt[0]) begin
                     count <= count + 10'd1;
                     word_lo <= {byte_in, word_lo[23:8]};
                  end
                  if (bit_cnt == 10'd1023) state <= CRC;
               end
               CRC: begin
                  for (int i = 0; i < 4; i++) crc[i] <= {crc[i][14:0], 1'b0};
                  crc_err <= crc_err || crc_bad;
                  bit_cnt <= bit_cnt + 10'd1;
                  if (bit_cnt[3:0] == 4'd15) state <= END;
               end
               END: begin
                  crc_err <= crc_err || sd_dat_in != 4'hF;
                  done <= 1'b1;
                  state <= IDLE;
                  sd_clk <= 1'b0;
                  div_cnt <= '0;
               end
               default: state <= IDLE;
            endcase
         if (wr && address == 2'd0) begin
            ie <= writedata[2];
            if (writedata[1]) begin
               state <= IDLE;
               sd_clk <= 1'b0;
               div_cnt <= '0;
            end else if (writedata[0] && !busy) begin
               state <= WAIT_START;
               done <= 1'b0;
               crc_err <= 1'b0;
               timeout <= 1'b0;
               bit_cnt <= '0;
               count <= '0;
               rd_ptr <= '0;
               to_cnt <= '0;
               crc <= '0;
               sd_clk <= 1'b0;
               div_cnt <= '0;
            end
         end
         if (rd)
            readdata <= address == 2'd0 ? {29'd0, ie, 2'd0} :
                        address == 2'd1 ? {28'd0, timeout, crc_err, done, busy} :
                        address == 2'd2 ? (busy ? 32'd0 : buffer[rd_ptr]) : {22'd0, count};
         if (rd && address == 2'd2 && !busy) rd_ptr <= rd_ptr + 7'd1;
      end
endmodule

// File: tb/tb_sd_dat_read_ctrl.sv
// tb_sd_dat_read_ctrl: directed bench with a card model and a read scoreboard.
module tb_sd_dat_read_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  address;
   logic        chipselect, read_n, write_n;
   logic [31:0] writedata, readdata;
   logic        irq, sd_clk;
   logic [3:0]  sd_dat_in;
   typedef struct { string tag; logic [31:0] val; } exp_t;
   exp_t sb[$];
   logic [3:0] stream[$];
   int tests = 0, fails = 0, sd_edges = 0, e0;
   logic [31:0] d;
   always #5 clk = ~clk;
   always @(posedge sd_clk) sd_edges++;
   sd_dat_read_ctrl #(.CLK_DIV(4), .TIMEOUT(100)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .irq(irq), .sd_clk(sd_clk), .sd_dat_in(sd_dat_in)
   );
   // card: next nibble goes out after each rising sd_clk
   initial forever begin
      @(posedge sd_clk);
      #1;
      if (stream.size() > 0) sd_dat_in = stream.pop_front();
      else sd_dat_in = 4'hF;
   end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic bus_wr(input logic [1:0] a, input logic [31:0] v);
      @(negedge clk);
      address = a; writedata = v; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask
   task automatic bus_rd(input logic [1:0] a, output logic [31:0] v);
      @(negedge clk);
      address = a; chipselect = 1'b1; read_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; read_n = 1'b1;
      v = readdata;
   endtask
   task automatic expect_rd(input logic [1:0] a, input logic [31:0] e, input string tag);
      exp_t x;
      sb.push_back('{tag, e});
      @(negedge clk);
      address = a; chipselect = 1'b1; read_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; read_n = 1'b1;
      x = sb.pop_front();
      check(x.tag, readdata, x.val);
   endtask
   task automatic wait_idle(input string tag);
      logic [31:0] v;
      int n = 0;
      do begin bus_rd(2'd1, v); n++; end while (v[0] && n < 8000);
      check({tag, "_idle_in_time"}, 32'(v[0]), 32'd0);
   endtask
   task automatic wait_count(input int target, input string tag);
      logic [31:0] v;
      int n = 0;
      do begin bus_rd(2'd3, v); n++; end while (v < 32'(target) && n < 8000);
      check(tag, 32'(v >= 32'(target)), 32'd1);
   endtask
   function automatic logic [3:0] nib(input int k);
      logic [7:0] b;
      b = 8'(k / 2);
      return (k % 2 == 0) ? b[7:4] : b[3:0];
   endfunction
   // remainder of message * x^16 divided by the generator
   function automatic logic [15:0] crc_of(input int line);
      logic [15:0] r;
      logic [3:0] n;
      logic m;
      r = '0;
      for (int k = 0; k < 1040; k++) begin
         n = (k < 1024) ? nib(k) : 4'h0;
         m = r[15];
         r = {r[14:0], n[line]};
         if (m) r = r ^ 16'h1021;
      end
      return r;
   endfunction
   function automatic logic [31:0] word(input int w);
      return {8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)};
   endfunction
   task automatic load(input bit flip);
      logic [15:0] c [4];
      logic [3:0] v;
      for (int i = 0; i < 4; i++) c[i] = crc_of(i);
      stream.delete();
      for (int k = 0; k < 10; k++) stream.push_back(4'hF);
      stream.push_back(4'h0);
      for (int k = 0; k < 1024; k++) stream.push_back(nib(k));
      for (int j = 0; j < 16; j++) begin
         v = {c[3][15 - j], c[2][15 - j], c[1][15 - j], c[0][15 - j]};
         if (flip && j == 5) v[2] = ~v[2];
         stream.push_back(v);
      end
      stream.push_back(4'hF);
      sd_dat_in = stream.pop_front();
   endtask
   initial begin
      chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; address = '0; writedata = '0; sd_dat_in = 4'hF;
      repeat (3) @(negedge clk);
      check("rst_readdata", readdata, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_sd_clk", 32'(sd_clk), 32'd0);
      reset = 1'b0;
      expect_rd(2'd1, 32'd0, "rst_status");
      expect_rd(2'd3, 32'd0, "rst_count");
      expect_rd(2'd0, 32'd0, "rst_ctrl");
      load(1'b0);
      bus_wr(2'd0, 32'h1);
      expect_rd(2'd2, 32'd0, "data_while_busy");
      expect_rd(2'd1, 32'h1, "busy_status");
      wait_idle("normal");
      expect_rd(2'd1, 32'h2, "normal_status");
      expect_rd(2'd3, 32'd512, "normal_count");
      check("normal_irq_ie0", 32'(irq), 32'd0);
      for (int i = 0; i < 129; i++) expect_rd(2'd2, word(i % 128), $sformatf("data_word%0d", i));
      load(1'b1);
      bus_wr(2'd0, 32'h1);
      wait_count(100, "crcerr_reach100");
      bus_wr(2'd0, 32'h1);
      bus_rd(2'd3, d);
      check("start_while_busy_count", 32'(d >= 32'd100), 32'd1);
      wait_idle("crcerr");
      expect_rd(2'd1, 32'h6, "crcerr_status");
      expect_rd(2'd3, 32'd512, "crcerr_count");
      e0 = sd_edges;
      bus_wr(2'd0, 32'h5);
      wait_idle("timeout");
      check("timeout_ticks", 32'(sd_edges - e0), 32'd99);
      expect_rd(2'd1, 32'hA, "timeout_status");
      check("timeout_sd_clk", 32'(sd_clk), 32'd0);
      check("timeout_irq", 32'(irq), 32'd1);
      bus_wr(2'd1, 32'hE);
      check("irq_cleared", 32'(irq), 32'd0);
      expect_rd(2'd1, 32'd0, "status_cleared");
      expect_rd(2'd0, 32'h4, "ctrl_ie");
      load(1'b0);
      bus_wr(2'd0, 32'h1);
      wait_count(200, "abort_reach200");
      bus_wr(2'd0, 32'h2);
      check("abort_sd_clk", 32'(sd_clk), 32'd0);
      stream.delete();
      sd_dat_in = 4'hF;
      expect_rd(2'd1, 32'd0, "abort_status");
      load(1'b0);
      bus_wr(2'd0, 32'h1);
      wait_idle("restart");
      expect_rd(2'd1, 32'h2, "restart_status");
      expect_rd(2'd3, 32'd512, "restart_count");
      expect_rd(2'd2, 32'h03020100, "restart_word0");
      bus_wr(2'd0, 32'h3);
      check("start_abort_sd_clk", 32'(sd_clk), 32'd0);
      expect_rd(2'd1, 32'h2, "start_abort_status");
      load(1'b0);
      bus_wr(2'd0, 32'h5);
      wait_count(300, "reset_reach300");
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_readdata", readdata, 32'd0);
      check("midrst_irq", 32'(irq), 32'd0);
      check("midrst_sd_clk", 32'(sd_clk), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      stream.delete();
      sd_dat_in = 4'hF;
      expect_rd(2'd1, 32'd0, "midrst_status");
      expect_rd(2'd3, 32'd0, "midrst_count");
      expect_rd(2'd0, 32'd0, "midrst_ctrl");
      check("midrst_irq_after", 32'(irq), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
